instr_fetch_unit: RTL

//  Fetch-side producer of the opcode stream consumed by the main control decoder.
//  - Keeps the PC and issues word fetches to instruction memory over a req/gnt/rvalid interface.
//  - Buffers returned words in a small in-order FIFO.
//  - Presents the head instruction, its PC and next_opCode to decode with a valid/ready handshake.
//  - Branch redirect: flushes buffered and in-flight fetches, then restarts at the target.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/instr_fetch_unit_if.sv | 39 +++
 rtl/instr_fetch_unit_fifo.sv | 64 ++++++
 rtl/instr_fetch_unit.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared opcode constants and fetch-unit types for the MIPS front end.
package mips_pkg;

  localparam int INSTR_W = 32;

  localparam logic [5:0] OPC_RTYPE  = 6'h00;
  localparam logic [5:0] OPC_ADDI   = 6'h08;
  localparam logic [5:0] OPC_LW     = 6'h23;
  localparam logic [5:0] OPC_SW     = 6'h2B;
  localparam logic [5:0] OPC_LH     = 6'h21;
  localparam logic [5:0] OPC_LHU    = 6'h25;
  localparam logic [5:0] OPC_BEQ    = 6'h04;
  // Not a real opcode: the decoder maps it to its all-zero default controls.
  localparam logic [5:0] OPC_BUBBLE = 6'h3F;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } ifu_state_t;

  function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory req/gnt/rvalid bus, decode valid/ready
// handshake and the branch redirect input.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  import mips_pkg::*;

  logic                imem_req;
  logic [ADDR_W-1:0]   imem_addr;
  logic                imem_gnt;
  logic                imem_rvalid;
  logic [INSTR_W-1:0]  imem_rdata;

  logic                if_valid;
  logic                if_ready;
  logic [INSTR_W-1:0]  if_instr;
  logic [ADDR_W-1:0]   if_pc;
  logic [5:0]          next_opCode;

  logic                br_taken;
  logic [ADDR_W-1:0]   br_target;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output if_valid, if_instr, if_pc, next_opCode,
    input  if_ready,
    input  br_taken, br_target
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  if_valid, if_instr, if_pc, next_opCode,
    output if_ready,
    output br_taken, br_target
  );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// In-order instruction buffer holding {instr, pc}; head is read straight from
// the storage registers so the outputs carry no combinational input path.
module ifu_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] push_instr,
  input  logic [PC_W-1:0]   push_pc,
  output logic [DATA_W-1:0] head_instr,
  output logic [PC_W-1:0]   head_pc,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem    [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      instr_mem[wr_ptr_reg] <= push_instr;
      pc_mem[wr_ptr_reg]    <= push_pc;
    end
  end

  assign head_instr = instr_mem[rd_ptr_reg];
  assign head_pc    = pc_mem[rd_ptr_reg];
  assign count      = count_reg;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    push |-> (!full || pop_ok));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, credit-limited fetch issue, in-order buffer and
// branch flush/drain. Define IFU_PERF_EN to add saturating pop/flush counters.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master bus
`ifdef IFU_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [15:0]        perf_flush_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  ifu_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [CNT_W-1:0]  outst_reg, outst_next;

  logic              credit_ok;
  logic              req;
  logic              issued;
  logic              resp_accept;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] resp_pc;

  logic [INSTR_W-1:0] head_instr;
  logic [ADDR_W-1:0]  head_pc;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic               fifo_full;

  // Buffered plus in-flight words may never exceed the buffer size, so every
  // response that arrives in FETCH is guaranteed a free slot.
  assign credit_ok = (SUM_W'(fifo_count) + SUM_W'(outst_reg)) < SUM_W'(FIFO_DEPTH);

  // Outstanding fetches in FETCH are always a contiguous run ending just
  // below pc_reg, so the oldest one's address needs no side storage.
  assign resp_pc = pc_reg - (ADDR_W'(outst_reg) << 2);

  assign pop = !fifo_empty && bus.if_ready;

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    req         = !reset && (state_reg == FETCH) && credit_ok;
    issued      = req && bus.imem_gnt;
    resp_accept = bus.imem_rvalid && (outst_reg != '0);
    push        = resp_accept && (state_reg == FETCH) && !bus.br_taken;
    outst_next  = outst_reg + CNT_W'(issued) - CNT_W'(resp_accept);

    if (bus.br_taken) begin
      pc_next = bus.br_target & ~ADDR_W'(3);
    end else if (issued) begin
      pc_next = pc_reg + ADDR_W'(4);
    end

    case (state_reg)
      FETCH:   if (bus.br_taken && (outst_next != '0)) state_next = DRAIN;
      DRAIN:   if (outst_next == '0) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= FETCH;
      pc_reg    <= RESET_PC;
      outst_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      outst_reg <= outst_next;
    end
  end

  ifu_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (INSTR_W),
    .PC_W   (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (bus.br_taken),
    .push_instr (bus.imem_rdata),
    .push_pc    (resp_pc),
    .head_instr (head_instr),
    .head_pc    (head_pc),
    .count      (fifo_count),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc_reg;
  assign bus.if_valid    = !fifo_empty;
  assign bus.if_instr    = head_instr;
  assign bus.if_pc       = head_pc;
  assign bus.next_opCode = fifo_empty ? OPC_BUBBLE : opcode_of(head_instr);

`ifdef IFU_PERF_EN
  logic [31:0] perf_fetch_cnt_reg;
  logic [15:0] perf_flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt_reg <= '0;
      perf_flush_cnt_reg <= '0;
    end else begin
      if (pop && (perf_fetch_cnt_reg != '1))
        perf_fetch_cnt_reg <= perf_fetch_cnt_reg + 32'd1;
      if (bus.br_taken && (perf_flush_cnt_reg != '1))
        perf_flush_cnt_reg <= perf_flush_cnt_reg + 16'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_cnt_reg;
  assign perf_flush_cnt = perf_flush_cnt_reg;
`endif

  // A response with nothing in flight is a memory-side protocol violation.
  a_rvalid_orphan: assert property (@(posedge clk) disable iff (reset)
    bus.imem_rvalid |-> (outst_reg != '0));

endmodule
